// File: rtl/iopage_intc.sv
// iopage_intc: parametrised iopage interrupt controller with registered arbitration
// Optional feature macro: IOPAGE_INTC_STATS_EN (COUNT register at BASE_ADDR+4)
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   iopage_addr_i           iopage byte address
//   data_in_i / data_out_o  write data / read data (0 when not decoded)
//   decode_o                implemented register hit while rd or wr is high
//   iopage_rd_i/_wr_i       read / write strobes
//   iopage_byte_op_i        byte write, iopage_addr_i[0] selects high byte
//   irq_i, irq_vec_i        level requests and per-channel vectors
//   irq_ack_o               one-cycle acknowledge pulse to the granted channel
//   interrupt_o, interrupt_ipl_o, vector_o  request posted to the CPU
//   ack_ipl_i               CPU acknowledge, one-hot by level
module iopage_intc #(
    parameter int                 NCHAN     = 4,
    parameter logic [3*NCHAN-1:0] CHAN_IPL  = {3'd6, 3'd5, 3'd4, 3'd4},
    parameter logic [12:0]        BASE_ADDR = 13'o17700
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [12:0]          iopage_addr_i,
    input  logic [15:0]          data_in_i,
    output logic [15:0]          data_out_o,
    output logic                 decode_o,
    input  logic                 iopage_rd_i,
    input  logic                 iopage_wr_i,
    input  logic                 iopage_byte_op_i,
    input  logic [NCHAN-1:0]     irq_i,
    input  logic [8*NCHAN-1:0]   irq_vec_i,
    output logic [NCHAN-1:0]     irq_ack_o,
    output logic                 interrupt_o,
    output logic [7:0]           interrupt_ipl_o,
    output logic [7:0]           vector_o,
    input  logic [7:0]           ack_ipl_i
);
    typedef enum logic [1:0] {IDLE, POSTED, ACK} state_t;
    state_t state_q, state_d;
    logic [NCHAN-1:0] mask_q, mask_d, holdoff_q, elig;
    logic [2:0] idx_q, ipl_q, win_idx, win_ipl;
    logic [7:0] vec_q, win_vec, irq8, mask8;
    logic [12:0] off;
    logic [15:0] cnt_rd;
    logic win_v, hi, sel_mask, sel_stat, sel_cnt, mask_we, unused;
    assign unused = ^data_in_i;
    assign off = iopage_addr_i - BASE_ADDR;
    assign sel_mask = off[12:3] == '0 && off[2:1] == 2'd0;
    assign sel_stat = off[12:3] == '0 && off[2:1] == 2'd1;
`ifdef IOPAGE_INTC_STATS_EN
    logic [15:0] count_q;
    assign sel_cnt = off[12:3] == '0 && off[2:1] == 2'd2;
    assign cnt_rd = count_q;
    always_ff @(posedge clk_i) begin
        if (reset_i)
            count_q <= '0;
        else if (iopage_wr_i && sel_cnt)
            count_q <= '0;
        else if (state_q == POSTED && state_d == ACK)
            count_q <= count_q + 16'd1;
    end
`else
    assign sel_cnt = 1'b0;
    assign cnt_rd = '0;
`endif
    assign decode_o = (sel_mask | sel_stat | sel_cnt) & (iopage_rd_i | iopage_wr_i);
    // a high-byte write leaves MASK untouched; all mask bits live in the low byte
    assign mask_we = iopage_wr_i && sel_mask && !(iopage_byte_op_i && iopage_addr_i[0]);
    // the FSM sees a mask write in the same cycle so the posted channel withdraws at that edge
    assign mask_d = mask_we ? data_in_i[NCHAN-1:0] : mask_q;
    assign elig = irq_i & ~mask_d & ~holdoff_q;
    assign irq8 = 8'(irq_i);
    assign mask8 = 8'(mask_d);
    always_comb begin
        win_v = 1'b0;
        win_idx = '0;
        win_ipl = '0;
        win_vec = '0;
        hi = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            // strict compare keeps the lowest index on IPL ties
            if (elig[i] && (!win_v || CHAN_IPL[3*i +: 3] > win_ipl)) begin
                win_v = 1'b1;
                win_idx = 3'(i);
                win_ipl = CHAN_IPL[3*i +: 3];
                win_vec = irq_vec_i[8*i +: 8];
            end
            if (elig[i] && CHAN_IPL[3*i +: 3] > ipl_q)
                hi = 1'b1;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = win_v ? POSTED : IDLE;
            POSTED:  state_d = ack_ipl_i[ipl_q] ? ACK :
                               (!irq8[idx_q] || mask8[idx_q] || hi) ? IDLE : POSTED;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            mask_q <= '0;
            holdoff_q <= '0;
            idx_q <= '0;
            ipl_q <= '0;
            vec_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q <= mask_d;
            holdoff_q <= irq_ack_o;
            if (state_q == IDLE && win_v) begin
                idx_q <= win_idx;
                ipl_q <= win_ipl;
                vec_q <= win_vec;
            end
        end
    end
    assign interrupt_o = state_q == POSTED;
    assign interrupt_ipl_o = interrupt_o ? 8'd1 << ipl_q : 8'd0;
    assign vector_o = interrupt_o ? vec_q : 8'd0;
    assign irq_ack_o = NCHAN'({7'd0, state_q == ACK} << idx_q);
    assign data_out_o = !decode_o ? 16'd0 :
                        sel_mask ? 16'(mask_q) :
                        sel_stat ? {interrupt_o, 1'b0, ipl_q, idx_q, irq8} : cnt_rd;
endmodule

// File: tb/tb_iopage_intc.sv
// tb_iopage_intc: directed self-checking bench for iopage_intc
module tb_iopage_intc;
    localparam logic [12:0] BASE = 13'o17700;
    logic clk = 1'b0, reset = 1'b0;
    logic [12:0] addr = '0;
    logic [15:0] din = '0, dout;
    logic decode, rd = 1'b0, wr = 1'b0, byte_op = 1'b0;
    logic [3:0] irq = '0, irq_ack;
    logic [31:0] irq_vec = {8'o230, 8'o224, 8'o220, 8'o214};
    logic interrupt;
    logic [7:0] ipl, vector, ack_ipl = '0;
    int checks = 0, passed = 0;

    iopage_intc dut (
        .clk_i(clk), .reset_i(reset), .iopage_addr_i(addr), .data_in_i(din),
        .data_out_o(dout), .decode_o(decode), .iopage_rd_i(rd), .iopage_wr_i(wr),
        .iopage_byte_op_i(byte_op), .irq_i(irq), .irq_vec_i(irq_vec), .irq_ack_o(irq_ack),
        .interrupt_o(interrupt), .interrupt_ipl_o(ipl), .vector_o(vector), .ack_ipl_i(ack_ipl)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (interrupt !== 1'b0) $display("FAIL reset_int: got %b want 0", interrupt); else passed++;
        checks++; if (ipl !== 8'h00) $display("FAIL reset_ipl: got %h want 00", ipl); else passed++;
        checks++; if (vector !== 8'h00) $display("FAIL reset_vec: got %h want 00", vector); else passed++;
        checks++; if (irq_ack !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", irq_ack); else passed++;
        addr = BASE; rd = 1'b1; #1;
        checks++; if ({decode, dout} !== {1'b1, 16'h0000}) $display("FAIL reset_mask: got %b/%h want 1/0000", decode, dout); else passed++;
        addr = BASE + 13'd2; #1;
        checks++; if (dout !== 16'h0000) $display("FAIL reset_status: got %h want 0000", dout); else passed++;
        rd = 1'b0;
    endtask

    task automatic test_single();
        irq = 4'b0010;
        tick();
        checks++; if ({interrupt, ipl, vector} !== {1'b1, 8'h10, 8'o220}) $display("FAIL single_post: got %b/%h/%o want 1/10/220", interrupt, ipl, vector); else passed++;
        ack_ipl = 8'h20;
        tick();
        checks++; if ({interrupt, irq_ack} !== {1'b1, 4'b0000}) $display("FAIL single_wrong_ack: got %b/%b want 1/0000", interrupt, irq_ack); else passed++;
        ack_ipl = 8'h10;
        tick();
        checks++; if ({irq_ack, interrupt, vector} !== {4'b0010, 1'b0, 8'h00}) $display("FAIL single_ack: got %b/%b/%h want 0010/0/00", irq_ack, interrupt, vector); else passed++;
        irq = '0; ack_ipl = '0;
        tick();
        checks++; if ({irq_ack, interrupt} !== {4'b0000, 1'b0}) $display("FAIL single_after: got %b/%b want 0000/0", irq_ack, interrupt); else passed++;
        tick();
    endtask

    task automatic test_tie();
        irq = 4'b0011;
        tick();
        checks++; if (vector !== 8'o214) $display("FAIL tie_first_vec: got %o want 214", vector); else passed++;
        ack_ipl = 8'h10;
        tick();
        checks++; if (irq_ack !== 4'b0001) $display("FAIL tie_first_ack: got %b want 0001", irq_ack); else passed++;
        irq = 4'b0010; ack_ipl = '0;
        tick();
        tick();
        checks++; if ({interrupt, vector} !== {1'b1, 8'o220}) $display("FAIL tie_second_post: got %b/%o want 1/220", interrupt, vector); else passed++;
        ack_ipl = 8'h10;
        tick();
        checks++; if (irq_ack !== 4'b0010) $display("FAIL tie_second_ack: got %b want 0010", irq_ack); else passed++;
        irq = '0; ack_ipl = '0;
        tick();
    endtask

    task automatic test_holdoff();
        irq = 4'b0001;
        tick();
        ack_ipl = 8'h10;
        tick();
        ack_ipl = '0;
        tick();
        tick();
        checks++; if (interrupt !== 1'b0) $display("FAIL holdoff_block: got %b want 0", interrupt); else passed++;
        tick();
        checks++; if (interrupt !== 1'b1) $display("FAIL holdoff_release: got %b want 1", interrupt); else passed++;
        irq = '0;
        tick();
    endtask

    task automatic test_preempt();
        irq = 4'b0001;
        tick();
        checks++; if (ipl !== 8'h10) $display("FAIL preempt_low: got %h want 10", ipl); else passed++;
        irq = 4'b1001;
        tick();
        checks++; if ({interrupt, irq_ack} !== {1'b0, 4'b0000}) $display("FAIL preempt_drop: got %b/%b want 0/0000", interrupt, irq_ack); else passed++;
        tick();
        checks++; if ({interrupt, ipl, vector, irq_ack} !== {1'b1, 8'h40, 8'o230, 4'b0000}) $display("FAIL preempt_post: got %b/%h/%o/%b want 1/40/230/0000", interrupt, ipl, vector, irq_ack); else passed++;
        ack_ipl = 8'h40;
        tick();
        checks++; if (irq_ack !== 4'b1000) $display("FAIL preempt_ack: got %b want 1000", irq_ack); else passed++;
        irq = 4'b0001; ack_ipl = '0;
        tick();
        tick();
        checks++; if ({interrupt, vector} !== {1'b1, 8'o214}) $display("FAIL preempt_repost: got %b/%o want 1/214", interrupt, vector); else passed++;
        irq = '0;
        tick();
        checks++; if ({interrupt, irq_ack} !== {1'b0, 4'b0000}) $display("FAIL withdraw_irq: got %b/%b want 0/0000", interrupt, irq_ack); else passed++;
    endtask

    task automatic test_mask_withdraw();
        irq = 4'b0010;
        tick();
        addr = BASE; din = 16'h0002; wr = 1'b1; #1;
        checks++; if (decode !== 1'b1) $display("FAIL mask_wr_decode: got %b want 1", decode); else passed++;
        tick();
        wr = 1'b0;
        checks++; if ({interrupt, irq_ack} !== {1'b0, 4'b0000}) $display("FAIL mask_withdraw: got %b/%b want 0/0000", interrupt, irq_ack); else passed++;
        addr = BASE + 13'd2; rd = 1'b1; #1;
        checks++; if (dout !== 16'h2102) $display("FAIL mask_status: got %h want 2102", dout); else passed++;
        addr = BASE; #1;
        checks++; if (dout !== 16'h0002) $display("FAIL mask_read: got %h want 0002", dout); else passed++;
        rd = 1'b0;
        tick();
        checks++; if (interrupt !== 1'b0) $display("FAIL mask_hold: got %b want 0", interrupt); else passed++;
    endtask

    task automatic test_byte_op();
        addr = BASE + 13'd1; din = 16'hFFFF; byte_op = 1'b1; wr = 1'b1;
        tick();
        wr = 1'b0; byte_op = 1'b0;
        addr = BASE; rd = 1'b1; #1;
        checks++; if (dout !== 16'h0002) $display("FAIL byte_high_ignored: got %h want 0002", dout); else passed++;
        addr = BASE + 13'd6; #1;
        checks++; if ({decode, dout} !== {1'b0, 16'h0000}) $display("FAIL no_decode_6: got %b/%h want 0/0000", decode, dout); else passed++;
        rd = 1'b0;
        addr = BASE + 13'd2; din = 16'hFFFF; wr = 1'b1; #1;
        checks++; if (decode !== 1'b1) $display("FAIL status_wr_decode: got %b want 1", decode); else passed++;
        tick();
        addr = BASE; din = 16'hFF00; byte_op = 1'b1;
        tick();
        wr = 1'b0; byte_op = 1'b0;
        checks++; if ({interrupt, vector} !== {1'b1, 8'o220}) $display("FAIL byte_low_unmask: got %b/%o want 1/220", interrupt, vector); else passed++;
        rd = 1'b1; #1;
        checks++; if (dout !== 16'h0000) $display("FAIL byte_low_mask: got %h want 0000", dout); else passed++;
        rd = 1'b0; irq = '0;
        tick();
    endtask

    task automatic test_reset_mid_posted();
        irq = 4'b0001;
        tick();
        checks++; if (interrupt !== 1'b1) $display("FAIL rst_mid_post: got %b want 1", interrupt); else passed++;
        reset = 1'b1; ack_ipl = 8'h10;
        tick();
        checks++; if ({interrupt, irq_ack} !== {1'b0, 4'b0000}) $display("FAIL rst_mid_drop: got %b/%b want 0/0000", interrupt, irq_ack); else passed++;
        reset = 1'b0; irq = '0; ack_ipl = '0;
        tick();
        checks++; if ({interrupt, irq_ack} !== {1'b0, 4'b0000}) $display("FAIL rst_mid_after: got %b/%b want 0/0000", interrupt, irq_ack); else passed++;
    endtask

    task automatic test_stats();
`ifdef IOPAGE_INTC_STATS_EN
        for (int k = 0; k < 3; k++) begin
            irq = 4'b0001;
            tick();
            ack_ipl = 8'h10;
            tick();
            irq = '0; ack_ipl = '0;
            tick();
            tick();
        end
        addr = BASE + 13'd4; rd = 1'b1; #1;
        checks++; if ({decode, dout} !== {1'b1, 16'd3}) $display("FAIL count_read: got %b/%h want 1/0003", decode, dout); else passed++;
        rd = 1'b0; wr = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b1; #1;
        checks++; if (dout !== 16'd0) $display("FAIL count_clear: got %h want 0000", dout); else passed++;
        rd = 1'b0;
`else
        addr = BASE + 13'd4; rd = 1'b1; #1;
        checks++; if ({decode, dout} !== {1'b0, 16'h0000}) $display("FAIL count_absent: got %b/%h want 0/0000", decode, dout); else passed++;
        rd = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_holdoff();
        test_preempt();
        test_mask_withdraw();
        test_byte_op();
        test_reset_mid_posted();
        test_stats();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
